grid_mem_arbiter: RTL and testbench
===================================

// Module: grid_mem_arbiter
// PURPOSE
//  Sole owner of one single-port 2-bit grid RAM (own or enemy board). Shares it between the
//  game FSM (highest priority, fixed latency, never stalled), a built-in board-clear sweep
//  and the display renderer (lowest priority, req/gnt). One instance per board, between
//  main_fsm and the grid RAM, with the VGA grid renderer as second reader.
// PARAMETERS
//  GRID_SIZE  10     cells per row/column swept by clear; cell (x,y) at address {x[3:0],y[3:0]}
//  CLEAR_VAL  2'b00  value written by the clear sweep (GRID_STATUS_EMPTY)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous, active-low reset
//  clr_start    in   1  1-cycle pulse: start a clear sweep of the board
//  clr_busy     out  1  sweep in progress
//  clr_done     out  1  1-cycle pulse: sweep finished
//  fsm_req      in   1  FSM access this cycle
//  fsm_w_nr     in   1  1 = write, 0 = read
//  fsm_addr     in   8  FSM cell address
//  fsm_wdata    in   2  FSM write data
//  fsm_rdata    out  2  FSM read data, valid while fsm_rvalid
//  fsm_rvalid   out  1  FSM read data valid
//  disp_req     in   1  display read request
//  disp_addr    in   8  display cell address
//  disp_gnt     out  1  display request accepted this cycle (combinational)
//  disp_rdata   out  2  display read data, valid while disp_rvalid
//  disp_rvalid  out  1  display read data valid
//  ram_addr     out  8  RAM address (registered)
//  ram_we       out  1  RAM write enable (registered)
//  ram_wdata    out  2  RAM write data (registered)
//  ram_rdata    in   2  RAM read data, 1 cycle after address presented
// BEHAVIOUR
//  - Reset: every output 0, state IDLE, sweep counters x=y=0, read-tag pipeline cleared.
//  - Arbitration in cycle N, priority fsm > clear > display. Winner's command is registered
//    onto ram_addr/ram_we/ram_wdata at end of N; with no winner ram_we=0, ram_addr holds.
//  - Read latency: read won in cycle N -> rvalid=1 for exactly cycle N+2, rdata=ram_rdata
//    (combinational pass-through, gated to 0 when rvalid=0). Writes produce no rvalid.
//  - 2-stage owner tag pipeline {none,fsm,disp} routes returning data; back-to-back reads
//    from either port every cycle sustain 1 result/cycle, order preserved.
//  - disp_gnt = disp_req & ~fsm_req & ~clr_busy. Ungranted display request is not queued;
//    renderer holds disp_req/disp_addr until gnt.
//  - FSM: IDLE, CLEAR.
//    IDLE: clr_start=1 -> CLEAR (clr_busy=1 from N+1), x=y=0.
//    CLEAR: each cycle with fsm_req=0 issue write CLEAR_VAL to {x,y}; y++, at y=GRID_SIZE-1
//    y=0,x++. Cycle with fsm_req=1: FSM wins, counters hold (sweep pauses, no cell skipped).
//    Write of cell (GRID_SIZE-1,GRID_SIZE-1) issued in cycle M -> IDLE; clr_busy=0 and
//    clr_done=1 in M+1 only. Uninterrupted sweep: GRID_SIZE^2 write cycles.
//  - clr_start while clr_busy: ignored (no restart). clr_start with fsm_req same cycle: accepted.
//  - Addresses passed unchecked (8'hff etc. forwarded as-is); only sweep limited to grid.
//  - rst_n low mid-sweep or mid-read: immediate abort, no clr_done, in-flight rvalid dropped.
// TESTING
//  1 fsm_req=1,w_nr=1,addr=8'h23,wdata=01 @N; read 8'h23 @N+1 -> ram_we=1 @N+1; fsm_rvalid=1,
//    fsm_rdata=01 @N+3.
//  2 disp_req=1 and fsm_req=1 (read) same cycle -> disp_gnt=0; next cycle fsm_req=0 ->
//    disp_gnt=1, disp_rvalid 2 cycles later; no fsm_rvalid/disp_rvalid overlap on one slot.
//  3 clr_start pulse, no other traffic -> 100 writes of 00 to {x,y} x,y 0..9, clr_done one
//    cycle after write to 8'h99, RAM model all-zero on grid cells, 8'hAA untouched.
//  4 fsm_req=1 for 3 cycles mid-sweep -> sweep pauses 3 cycles, still 100 distinct clear
//    writes, clr_done delayed by 3; disp_gnt=0 throughout clr_busy.
//  5 clr_start again while busy -> ignored, single clr_done; rst_n low mid-sweep -> all
//    outputs 0 at once, no clr_done after release.
//  6 alternating fsm/disp reads every cycle for 20 cycles -> each rvalid exactly 2 cycles
//    after its issue, data matches RAM model, none lost.

Source files
------------

// File: rtl/grid_mem_arbiter.sv
// grid_mem_arbiter
//   Sole owner of one single-port 2-bit grid RAM. Shares the RAM between the
//   game FSM (highest priority, fixed latency, never stalled), a built-in
//   board-clear sweep and the display renderer (lowest priority, req/gnt).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   clr_start                  1-cycle pulse starting a clear sweep
//   clr_busy / clr_done        sweep in progress / 1-cycle completion pulse
//   fsm_req, fsm_w_nr,
//   fsm_addr, fsm_wdata        FSM access (w_nr: 1 = write, 0 = read)
//   fsm_rdata / fsm_rvalid     FSM read data, 2 cycles after the request
//   disp_req, disp_addr        display read request (held until granted)
//   disp_gnt                   display request accepted this cycle
//   disp_rdata / disp_rvalid   display read data, 2 cycles after the grant
//   ram_addr, ram_we,
//   ram_wdata                  registered RAM command
//   ram_rdata                  RAM read data, 1 cycle after address presented

module grid_mem_arbiter #(
    parameter int unsigned GRID_SIZE = 10,
    parameter logic [1:0]  CLEAR_VAL = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_start,
    output logic       clr_busy,
    output logic       clr_done,
    input  logic       fsm_req,
    input  logic       fsm_w_nr,
    input  logic [7:0] fsm_addr,
    input  logic [1:0] fsm_wdata,
    output logic [1:0] fsm_rdata,
    output logic       fsm_rvalid,
    input  logic       disp_req,
    input  logic [7:0] disp_addr,
    output logic       disp_gnt,
    output logic [1:0] disp_rdata,
    output logic       disp_rvalid,
    output logic [7:0] ram_addr,
    output logic       ram_we,
    output logic [1:0] ram_wdata,
    input  logic [1:0] ram_rdata
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_FSM  = 2'd1;
    localparam logic [1:0] TAG_DISP = 2'd2;

    localparam logic [3:0] LAST = 4'(GRID_SIZE - 1);

    logic [0:0] state;
    logic [3:0] clr_x;
    logic [3:0] clr_y;
    logic       clr_done_q;
    logic [1:0] tag_q1;
    logic [1:0] tag_q2;

    logic       clr_issue;
    logic       clr_last;
    logic [1:0] tag_new;

    assign clr_busy  = (state == ST_CLEAR);
    assign clr_done  = clr_done_q;
    assign disp_gnt  = disp_req & ~fsm_req & ~clr_busy;

    // The sweep only issues on cycles the FSM leaves free, so an FSM burst
    // pauses it without skipping any cell.
    assign clr_issue = clr_busy & ~fsm_req;
    assign clr_last  = clr_issue & (clr_x == LAST) & (clr_y == LAST);

    always_comb begin
        tag_new = TAG_NONE;
        if (fsm_req && !fsm_w_nr) begin
            tag_new = TAG_FSM;
        end else if (disp_gnt) begin
            tag_new = TAG_DISP;
        end
    end

    // Registered RAM command: fsm > clear > display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else if (fsm_req) begin
            ram_addr  <= fsm_addr;
            ram_we    <= fsm_w_nr;
            ram_wdata <= fsm_wdata;
        end else if (clr_issue) begin
            ram_addr  <= {clr_x, clr_y};
            ram_we    <= 1'b1;
            ram_wdata <= CLEAR_VAL;
        end else if (disp_gnt) begin
            ram_addr  <= disp_addr;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            ram_we    <= 1'b0;
        end
    end

    // Owner tags follow each read through the two cycles of RAM latency
    // (register stage + RAM stage) so returning data reaches the right port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q1 <= TAG_NONE;
            tag_q2 <= TAG_NONE;
        end else begin
            tag_q1 <= tag_new;
            tag_q2 <= tag_q1;
        end
    end

    assign fsm_rvalid  = (tag_q2 == TAG_FSM);
    assign disp_rvalid = (tag_q2 == TAG_DISP);
    assign fsm_rdata   = fsm_rvalid  ? ram_rdata : '0;
    assign disp_rdata  = disp_rvalid ? ram_rdata : '0;

    // Clear sweep: y is the fast index, x the slow one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            clr_x      <= '0;
            clr_y      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= clr_last;
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state <= ST_CLEAR;
                        clr_x <= '0;
                        clr_y <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_issue) begin
                        if (clr_y == LAST) begin
                            clr_y <= '0;
                            if (clr_x == LAST) begin
                                state <= ST_IDLE;
                            end else begin
                                clr_x <= clr_x + 4'd1;
                            end
                        end else begin
                            clr_y <= clr_y + 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// tb_grid_mem_arbiter
//   Self-checking bench for grid_mem_arbiter: directed vector table, multi-
//   cycle clear/reset sequences and randomized traffic against a
//   transaction-level model of the arbiter plus a behavioural RAM.

module tb_grid_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_start;
    logic       clr_busy;
    logic       clr_done;
    logic       fsm_req;
    logic       fsm_w_nr;
    logic [7:0] fsm_addr;
    logic [1:0] fsm_wdata;
    logic [1:0] fsm_rdata;
    logic       fsm_rvalid;
    logic       disp_req;
    logic [7:0] disp_addr;
    logic       disp_gnt;
    logic [1:0] disp_rdata;
    logic       disp_rvalid;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [1:0] ram_wdata;
    logic [1:0] ram_rdata;

    always #5 clk = ~clk;

    grid_mem_arbiter #(.GRID_SIZE(10), .CLEAR_VAL(2'b00)) dut (
        .clk(clk), .rst_n(rst_n),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .fsm_req(fsm_req), .fsm_w_nr(fsm_w_nr), .fsm_addr(fsm_addr),
        .fsm_wdata(fsm_wdata), .fsm_rdata(fsm_rdata), .fsm_rvalid(fsm_rvalid),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Behavioural single-port RAM, initial content = low two address bits.
    logic [1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 2'(i);
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            ram_rdata <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_wdata;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        bit         disp;
        logic [7:0] addr;
    } rd_t;

    rd_t        rq[$];
    logic [1:0] shadow [256];
    bit         m_busy, m_done, m_we;
    int         m_k;
    logic [7:0] m_raddr;
    logic [1:0] m_wdata;
    int         cyc;

    int checks = 0;
    int failures = 0;
    int n_done = 0, n_we = 0, n_rv = 0, last_done = -1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare every output
    // against the model, then advance the model across the next rising edge.
    task automatic tick(input bit fr, input bit w, input logic [7:0] fa, input logic [1:0] fd,
                        input bit dr, input logic [7:0] da, input bit cs);
        bit         e_gnt, e_frv, e_drv, nd, start_ok;
        logic [1:0] e_dat;
        rd_t        r;
        @(negedge clk);
        fsm_req = fr; fsm_w_nr = w; fsm_addr = fa; fsm_wdata = fd;
        disp_req = dr; disp_addr = da; clr_start = cs;
        #1;
        e_gnt = dr && !fr && !m_busy;
        e_frv = 1'b0; e_drv = 1'b0; e_dat = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            e_dat = shadow[r.addr];
            if (r.disp) e_drv = 1'b1; else e_frv = 1'b1;
        end
        chk("disp_gnt", disp_gnt, e_gnt);
        chk("clr_busy", clr_busy, m_busy);
        chk("clr_done", clr_done, m_done);
        chk("ram_we", ram_we, m_we);
        chk("ram_addr", ram_addr, m_raddr);
        if (m_we) chk("ram_wdata", ram_wdata, m_wdata);
        chk("fsm_rvalid", fsm_rvalid, e_frv);
        chk("fsm_rdata", fsm_rdata, e_frv ? e_dat : 2'b00);
        chk("disp_rvalid", disp_rvalid, e_drv);
        chk("disp_rdata", disp_rdata, e_drv ? e_dat : 2'b00);
        if (clr_done) begin n_done++; last_done = cyc; end
        if (ram_we) n_we++;
        if (fsm_rvalid || disp_rvalid) n_rv++;

        // model advance
        if (m_we) shadow[m_raddr] = m_wdata;
        nd = 1'b0;
        start_ok = !m_busy && cs;
        if (fr) begin
            m_raddr = fa; m_we = w;
            if (w) m_wdata = fd;
            else rq.push_back('{cyc + 2, 1'b0, fa});
        end else if (m_busy) begin
            m_raddr = 8'((m_k / 10) * 16 + (m_k % 10));
            m_we = 1'b1; m_wdata = 2'b00;
            m_k++;
            if (m_k == 100) begin m_busy = 1'b0; nd = 1'b1; end
        end else if (e_gnt) begin
            m_raddr = da; m_we = 1'b0;
            rq.push_back('{cyc + 2, 1'b1, da});
        end else begin
            m_we = 1'b0;
        end
        m_done = nd;
        if (start_ok) begin m_busy = 1'b1; m_k = 0; end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 2'b00, 0, 8'h00, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        fsm_req = 0; fsm_w_nr = 0; fsm_addr = '0; fsm_wdata = '0;
        disp_req = 0; disp_addr = '0; clr_start = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_fsm_rvalid", fsm_rvalid, 0);
        chk("rst_fsm_rdata", fsm_rdata, 0);
        chk("rst_disp_gnt", disp_gnt, 0);
        chk("rst_disp_rvalid", disp_rvalid, 0);
        chk("rst_disp_rdata", disp_rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        m_busy = 0; m_done = 0; m_we = 0; m_raddr = '0; m_wdata = '0;
        rq.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc++;
    endtask

    typedef struct {
        bit fr; bit w; logic [7:0] fa; logic [1:0] fd; bit dr; logic [7:0] da;
        bit e_gnt; bit e_frv; logic [1:0] e_frd; bit e_drv; logic [1:0] e_drd; bit e_we;
    } vec_t;

    vec_t vt[8];
    int   s, we0, rv0, d0;

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 2'(i);
        cyc = 0; m_k = 0;
        rst_n = 1'b0;
        fsm_req = 0; fsm_w_nr = 0; fsm_addr = '0; fsm_wdata = '0;
        disp_req = 0; disp_addr = '0; clr_start = 0;
        do_reset();

        // write/read latency and display arbitration
        vt[0] = '{1'b1, 1'b1, 8'h23, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
        vt[1] = '{1'b1, 1'b0, 8'h23, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1};
        vt[2] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
        vt[3] = '{1'b1, 1'b0, 8'h12, 2'b00, 1'b1, 8'h45, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0};
        vt[4] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 8'h45, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
        vt[5] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0};
        vt[6] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0};
        vt[7] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
        for (int i = 0; i < 8; i++) begin
            tick(vt[i].fr, vt[i].w, vt[i].fa, vt[i].fd, vt[i].dr, vt[i].da, 0);
            chk("vec_disp_gnt", disp_gnt, vt[i].e_gnt);
            chk("vec_fsm_rvalid", fsm_rvalid, vt[i].e_frv);
            chk("vec_fsm_rdata", fsm_rdata, vt[i].e_frd);
            chk("vec_disp_rvalid", disp_rvalid, vt[i].e_drv);
            chk("vec_disp_rdata", disp_rdata, vt[i].e_drd);
            chk("vec_ram_we", ram_we, vt[i].e_we);
        end

        // uninterrupted sweep
        s = cyc; we0 = n_we; d0 = n_done;
        tick(0, 0, 8'h00, 2'b00, 0, 8'h00, 1);
        idle(110);
        chk("sweep_writes", 8'(n_we - we0), 8'd100);
        chk("sweep_done_cnt", 8'(n_done - d0), 8'd1);
        chk("sweep_done_cycle", 8'(last_done - s), 8'd101);
        for (int x = 0; x < 10; x++)
            for (int y = 0; y < 10; y++)
                chk("sweep_cell", {6'b0, mem[x * 16 + y]}, 8'h00);
        chk("sweep_aa_untouched", {6'b0, mem[8'hAA]}, 8'h02);

        // sweep paused by 3 FSM cycles, display held off while busy
        s = cyc; we0 = n_we; d0 = n_done;
        tick(0, 0, 8'h00, 2'b00, 1, 8'h33, 1);
        for (int i = 0; i < 20; i++) tick(0, 0, 8'h00, 2'b00, 1, 8'h33, 0);
        for (int i = 0; i < 3; i++) tick(1, 0, 8'hAA, 2'b00, 1, 8'h33, 0);
        for (int i = 0; i < 90; i++) tick(0, 0, 8'h00, 2'b00, 1, 8'h33, 0);
        idle(5);
        chk("pause_done_cycle", 8'(last_done - s), 8'd104);
        chk("pause_done_cnt", 8'(n_done - d0), 8'd1);
        chk("pause_writes", 8'(n_we - we0), 8'd100);

        // restart attempt while busy is ignored
        s = cyc; d0 = n_done;
        tick(0, 0, 8'h00, 2'b00, 0, 8'h00, 1);
        idle(10);
        tick(0, 0, 8'h00, 2'b00, 0, 8'h00, 1);
        idle(100);
        chk("restart_done_cnt", 8'(n_done - d0), 8'd1);
        chk("restart_done_cycle", 8'(last_done - s), 8'd101);

        // reset mid-sweep with a read in flight
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
        d0 = n_done;
        tick(0, 0, 8'h00, 2'b00, 0, 8'h00, 1);
        idle(30);
        tick(1, 0, 8'h23, 2'b00, 0, 8'h00, 0);
        do_reset();
        rv0 = n_rv;
        idle(120);
        chk("abort_no_done", 8'(n_done - d0), 8'd0);
        chk("abort_no_rvalid", 8'(n_rv - rv0), 8'd0);

        // alternating back-to-back reads
        rv0 = n_rv;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) tick(1, 0, 8'($urandom), 2'b00, 0, 8'h00, 0);
            else            tick(0, 0, 8'h00, 2'b00, 1, 8'($urandom), 0);
        end
        idle(3);
        chk("alt_reads_returned", 8'(n_rv - rv0), 8'd20);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            tick(($urandom % 3) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
                 2'($urandom), $urandom_range(0, 1) == 1, 8'($urandom),
                 ($urandom % 80) == 0);
        end
        idle(110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
